// File: rtl/register_file_if.sv
// Bus bundle for register_file: one write port and two read ports.
// master drives addresses/data, slave (the register bank) returns read data and flags.
interface register_file_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              load;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  out_a;
    logic              valid_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  out_b;
    logic              valid_b;

    modport master (
        output load, waddr, in, raddr_a, raddr_b,
        input  out_a, valid_a, out_b, valid_b
    );

    modport slave (
        input  load, waddr, in, raddr_a, raddr_b,
        output out_a, valid_a, out_b, valid_b
    );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x WIDTH register bank, one write port, two combinational read ports, per-entry written flags.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            written <= '0;
        end else if (bus.load) begin
            mem[bus.waddr]     <= bus.in;
            written[bus.waddr] <= 1'b1;
        end
    end

    always_comb begin
        bus.out_a   = mem[bus.raddr_a];
        bus.valid_a = written[bus.raddr_a];
        bus.out_b   = mem[bus.raddr_b];
        bus.valid_b = written[bus.raddr_b];
`ifdef REGFILE_BYPASS_EN
        // Reset blocks the forward so reads reflect stored state during reset.
        if (bus.load && !reset) begin
            if (bus.raddr_a == bus.waddr) begin
                bus.out_a   = bus.in;
                bus.valid_a = 1'b1;
            end
            if (bus.raddr_b == bus.waddr) begin
                bus.out_b   = bus.in;
                bus.valid_b = 1'b1;
            end
        end
`else
`endif
    end
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file at default, 8x2 and 32x16 geometries.
module tb_register_file;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(16), .ADDR_W(3)) m   ();
    register_file_if #(.WIDTH(8),  .ADDR_W(1)) s8  ();
    register_file_if #(.WIDTH(32), .ADDR_W(4)) s32 ();

    register_file #(.WIDTH(16), .ADDR_W(3)) dut_main (.clk(clk), .reset(reset), .bus(m));
    register_file #(.WIDTH(8),  .ADDR_W(1)) dut_s8   (.clk(clk), .reset(reset), .bus(s8));
    register_file #(.WIDTH(32), .ADDR_W(4)) dut_s32  (.clk(clk), .reset(reset), .bus(s32));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp16 [8];
    logic [31:0] exp32 [16];
    logic [7:0]  exp8  [2];

    initial begin
        exp16 = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        exp8  = '{8'h80, 8'h7F};
        for (int i = 0; i < 16; i++) exp32[i] = 32'h1000_0000 + 32'(i);
        exp32[0] = 32'h8000_0000;
        exp32[1] = 32'h7FFF_FFFF;

        reset = 1'b1;
        m.load = 1'b0;   m.waddr = '0;   m.in = '0;   m.raddr_a = '0;   m.raddr_b = '0;
        s8.load = 1'b0;  s8.waddr = '0;  s8.in = '0;  s8.raddr_a = '0;  s8.raddr_b = '0;
        s32.load = 1'b0; s32.waddr = '0; s32.in = '0; s32.raddr_a = '0; s32.raddr_b = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle sweep
        for (int i = 0; i < 8; i++) begin
            m.raddr_a = 3'(i);
            m.raddr_b = 3'(7 - i);
            #1;
            check($sformatf("rst_out_a[%0d]", i), 64'(m.out_a), 64'd0);
            check($sformatf("rst_val_a[%0d]", i), 64'(m.valid_a), 64'd0);
            check($sformatf("rst_out_b[%0d]", i), 64'(m.out_b), 64'd0);
            check($sformatf("rst_val_b[%0d]", i), 64'(m.valid_b), 64'd0);
        end

        // Write all entries, then cross-read
        for (int i = 0; i < 8; i++) begin
            m.load = 1'b1;
            m.waddr = 3'(i);
            m.in = exp16[i];
            tick();
        end
        m.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m.raddr_a = 3'(i);
            m.raddr_b = 3'(7 - i);
            #1;
            check($sformatf("wr_out_a[%0d]", i), 64'(m.out_a), 64'(exp16[i]));
            check($sformatf("wr_val_a[%0d]", i), 64'(m.valid_a), 64'd1);
            check($sformatf("wr_out_b[%0d]", i), 64'(m.out_b), 64'(exp16[7 - i]));
            check($sformatf("wr_val_b[%0d]", i), 64'(m.valid_b), 64'd1);
        end

        // Load gating
        m.load = 1'b1; m.waddr = 3'd3; m.in = 16'd1234;
        tick();
        m.load = 1'b0; m.in = 16'hFFB3; m.raddr_a = 3'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gate_out_a[%0d]", i), 64'(m.out_a), 64'd1234);
        end

        // Same-cycle write and read
        m.raddr_a = 3'd5; m.waddr = 3'd5; m.in = 16'd4660; m.load = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_out_a", 64'(m.out_a), 64'd4660);
`else
        check("same_cyc_out_a", 64'(m.out_a), 64'd3);
`endif
        check("same_cyc_val_a", 64'(m.valid_a), 64'd1);
        tick();
        m.load = 1'b0;
        #1;
        check("after_edge_out_a", 64'(m.out_a), 64'd4660);

        // Reset mid-operation discards the coincident write
        m.load = 1'b1; m.waddr = 3'd2; m.in = 16'd99;
        tick();
        m.raddr_a = 3'd2; m.raddr_b = 3'd0;
        m.in = 16'd55; reset = 1'b1;
        #1;
        check("rst_cyc_out_a", 64'(m.out_a), 64'd99);
        tick();
        check("midrst_out_a", 64'(m.out_a), 64'd0);
        check("midrst_val_a", 64'(m.valid_a), 64'd0);
        check("midrst_out_b", 64'(m.out_b), 64'd0);
        check("midrst_val_b", 64'(m.valid_b), 64'd0);
        reset = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("post_rst_pre_out_a", 64'(m.out_a), 64'd55);
`else
        check("post_rst_pre_out_a", 64'(m.out_a), 64'd0);
`endif
        tick();
        m.load = 1'b0;
        #1;
        check("post_rst_out_a", 64'(m.out_a), 64'd55);
        check("post_rst_val_a", 64'(m.valid_a), 64'd1);

        // Back-to-back writes: last wins
        m.load = 1'b1; m.waddr = 3'd6; m.in = 16'd10;
        tick();
        m.in = 16'd20;
        tick();
        m.load = 1'b0; m.raddr_b = 3'd6;
        #1;
        check("b2b_out_b", 64'(m.out_b), 64'd20);

        // 8-bit, 2-entry geometry
        for (int i = 0; i < 2; i++) begin
            s8.load = 1'b1; s8.waddr = 1'(i); s8.in = exp8[i];
            tick();
        end
        s8.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s8.raddr_a = 1'(i);
            s8.raddr_b = 1'(1 - i);
            #1;
            check($sformatf("s8_out_a[%0d]", i), 64'(s8.out_a), 64'(exp8[i]));
            check($sformatf("s8_out_b[%0d]", i), 64'(s8.out_b), 64'(exp8[1 - i]));
            check($sformatf("s8_val_a[%0d]", i), 64'(s8.valid_a), 64'd1);
        end

        // 32-bit, 16-entry geometry
        for (int i = 0; i < 16; i++) begin
            s32.load = 1'b1; s32.waddr = 4'(i); s32.in = exp32[i];
            tick();
        end
        s32.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s32.raddr_a = 4'(i);
            s32.raddr_b = 4'(15 - i);
            #1;
            check($sformatf("s32_out_a[%0d]", i), 64'(s32.out_a), 64'(exp32[i]));
            check($sformatf("s32_out_b[%0d]", i), 64'(s32.out_b), 64'(exp32[15 - i]));
            check($sformatf("s32_val_b[%0d]", i), 64'(s32.valid_b), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register bank with one write port and two independent read ports. It generalises the single 16-bit load register to 2**ADDR_W entries of WIDTH bits and adds per-entry written-since-reset flags. It sits between the ALU and the control datapath as the CPU's general register store, and it can also serve as a RAM8-class memory building block.

## Interface
- WIDTH, 16, data width of each entry in bits (≥1)
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W entries (≥1)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all entries and valid flags
- load  input  1  write enable for the current cycle
- waddr  input  ADDR_W  write address
- in  input  WIDTH  write data, treated as signed two's complement
- raddr_a  input  ADDR_W  read port A address
- out_a  output  WIDTH  read port A data
- valid_a  output  1  entry at raddr_a has been written since last reset
- raddr_b  input  ADDR_W  read port B address
- out_b  output  WIDTH  read port B data
- valid_b  output  1  entry at raddr_b has been written since last reset

## Operation
- Storage: DEPTH × WIDTH entry array plus a DEPTH-bit written flag vector.
- Write: at a rising edge with load=1 and reset=0, entry[waddr] ← in and flag[waddr] ← 1. With load=0 all state holds.
- Read: out_a = entry[raddr_a], valid_a = flag[raddr_a]. Port B works the same way. Reads are combinational from stored state, so no clock is needed to read.
- Both read ports may address the same entry. Each returns identical data.
- Reset: at a rising edge with reset=1, every entry becomes 0 and every flag becomes 0. Reset overrides load in the same cycle, so the write is discarded.
- Reset reaching the block mid-sequence loses all prior writes. The first write after reset deasserts takes effect at the next edge.
- Data is stored bit-exact. The block performs no sign extension, saturation or arithmetic.
- An address is always in range because DEPTH = 2**ADDR_W. The block has no wrap logic.

## Timing
- Write latency: data presented with load=1 becomes visible on a matching read port in the cycle after the edge (1-cycle write-to-read), unless bypass is compiled in.
- Read latency: 0 cycles, combinational from raddr_* and stored state.
- Reset values after the first reset edge: all entries 0, out_a=0, out_b=0, valid_a=0, valid_b=0.
- Outputs before the first reset edge are undefined. The bench must assert reset for ≥1 edge before checking.
- Simultaneous write and read to the same address without bypass: the read returns the old value during that cycle and the new value after the edge.
- Back-to-back writes to one address: the last write wins, one entry per edge.

## Configuration
- REGFILE_BYPASS_EN defined: a write-to-read bypass is compiled in.
  - When load=1, reset=0 and raddr_x == waddr, out_x = in and valid_x = 1 combinationally in the same cycle.
  - This gives 0-cycle write-to-read latency.
  - Reset=1 suppresses the bypass, so outputs reflect stored state.
- REGFILE_BYPASS_EN undefined: there is no bypass path. Read ports see stored state only.

## Test plan
- Reset then idle: hold reset=1 for 2 edges, then sweep raddr_a/raddr_b over 0..7 → every read returns out=0 and valid=0.
- Write/read all entries: write -1, 0x7FFF, -32768, 1, 2, 3, 4, 5 to addresses 0..7, then read A=i and B=7-i → each port returns the stored value and valid=1 on every address.
- Load gating: entry 3 = 1234; present in=-77, waddr=3, load=0 for 3 edges → out_a at raddr_a=3 stays 1234.
- Same-cycle write/read: write 4660 to addr 5 with raddr_a=5.
  - Without REGFILE_BYPASS_EN: out_a shows the old value in that cycle and 4660 after the edge.
  - With REGFILE_BYPASS_EN: out_a = 4660 and valid_a = 1 in the same cycle.
- Reset mid-operation: write 99 to addr 2, then assert reset and load together with in=55, waddr=2 → after the edge out=0 and valid=0 at addr 2. The next write of 55 appears one edge later.
- Parameter sweep: WIDTH=8, ADDR_W=1 and WIDTH=32, ADDR_W=4 → run the write/read-all scenario. Values -128/127 and 0x80000000/0x7FFFFFFF store bit-exact.
